// File: rtl/rca_seq_addsub.sv
// Multi-cycle ripple-carry adder/subtractor, CHUNK bits per clock, LSB first.
// Define OVERFLOW_FLAG_EN to add the registered signed-overflow output.
module rca_seq_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);

  if (WIDTH < 2) begin : g_width_check
    $error("rca_seq_addsub: WIDTH must be at least 2");
  end
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_chunk_check
    $error("rca_seq_addsub: CHUNK must divide WIDTH exactly");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_cmsb;
  logic             c;

  // Ripple chain over the low CHUNK bits; chunk_cmsb keeps the carry into the top bit.
  always_comb begin
    c          = carry_q;
    chunk_cmsb = carry_q;
    chunk_sum  = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      chunk_cmsb   = c;
      chunk_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    chunk_cout = c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        // Result bits enter from the MSB side so the first chunk ends up at bit 0.
        res_d   = (WIDTH'(chunk_sum) << (WIDTH - CHUNK)) | (res_q >> CHUNK);
        carry_d = chunk_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_d == CW'(N)) begin
          sum_d   = res_d;
          cout_d  = chunk_cout;
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = chunk_cmsb ^ chunk_cout;
`endif
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign overflow = ovf_q;
`endif

endmodule
